// File: rtl/display_clock_reconfig.sv
// display_clock_reconfig
//   DRP reconfiguration sequencer for the display MMCM. On request it holds the
//   MMCM in reset, read-modify-writes one mode's register set taken from an
//   external table ROM, releases reset and waits for lock. Runs on the system
//   clock that also drives the MMCM DCLK.
// Ports
//   i_clk / i_rst_n       system clock (= DCLK), async active-low reset
//   i_req / i_mode        start request (taken only while not busy), mode index
//   o_busy/o_done/o_err   status: in progress, 1-cycle finish pulse, sticky error
//   o_clk_valid           configured, idle and lock (synchronised) high
//   o_rom_addr/i_rom_data {mode,entry} lookup; ROM is registered (1-cycle)
//                         data = [38:32] DRP addr, [31:16] keep-mask, [15:0] value
//   o_drp_*/i_drp_*       MMCM DRP port
//   o_mmcm_rst            MMCM RST (active high); i_mmcm_locked raw LOCKED
module display_clock_reconfig #(
  parameter int MODES        = 2,
  parameter int ENTRIES      = 23,
  parameter int RST_HOLD     = 16,
  parameter int DRP_TIMEOUT  = 64,
  parameter int LOCK_TIMEOUT = 1 << 20,
  parameter int RETRIES      = 2,
  parameter int AUTO_START   = 1,
  localparam int MW = (MODES   > 1) ? $clog2(MODES)   : 1,
  localparam int EW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_req,
  input  logic [MW-1:0]  i_mode,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_err,
  output logic           o_clk_valid,
  output logic [MW+EW-1:0] o_rom_addr,
  input  logic [38:0]    i_rom_data,
  output logic           o_drp_den,
  output logic           o_drp_dwe,
  output logic [6:0]     o_drp_daddr,
  output logic [15:0]    o_drp_di,
  input  logic [15:0]    i_drp_do,
  input  logic           i_drp_drdy,
  output logic           o_mmcm_rst,
  input  logic           i_mmcm_locked
);
  localparam int HW = (RST_HOLD     > 0) ? $clog2(RST_HOLD + 1)     : 1;
  localparam int DW = (DRP_TIMEOUT  > 0) ? $clog2(DRP_TIMEOUT + 1)  : 1;
  localparam int LW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam int RW = (RETRIES      > 0) ? $clog2(RETRIES + 1)      : 1;

  typedef enum logic [3:0] {
    IDLE, HOLD, ROM, RD, RD_WAIT, WR, WR_WAIT, RELEASE, LOCK_WAIT, ERROR
  } state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   mode_q, mode_d;
  logic [EW-1:0]   idx_q, idx_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [DW-1:0]   drp_q, drp_d;
  logic [LW-1:0]   lock_q, lock_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [6:0]      addr_q, addr_d;
  logic [15:0]     mask_q, mask_d, val_q, val_d, di_q, di_d;
  logic            err_q, err_d, done_q, done_d, cfg_q, cfg_d;
  logic            rst_q, rst_d, auto_q, auto_d;
  logic            lk_meta_q, lk_sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= (AUTO_START != 0) ? HOLD : IDLE;
      mode_q    <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      drp_q     <= '0;
      lock_q    <= '0;
      retry_q   <= '0;
      addr_q    <= '0;
      mask_q    <= '0;
      val_q     <= '0;
      di_q      <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      cfg_q     <= 1'b0;
      rst_q     <= 1'b1;
      auto_q    <= (AUTO_START != 0);
      lk_meta_q <= 1'b0;
      lk_sync_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      drp_q     <= drp_d;
      lock_q    <= lock_d;
      retry_q   <= retry_d;
      addr_q    <= addr_d;
      mask_q    <= mask_d;
      val_q     <= val_d;
      di_q      <= di_d;
      err_q     <= err_d;
      done_q    <= done_d;
      cfg_q     <= cfg_d;
      rst_q     <= rst_d;
      auto_q    <= auto_d;
      lk_meta_q <= i_mmcm_locked;
      lk_sync_q <= lk_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    drp_d   = drp_q;
    lock_d  = lock_q;
    retry_d = retry_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    val_d   = val_q;
    di_d    = di_q;
    err_d   = err_q;
    done_d  = 1'b0;
    cfg_d   = cfg_q;
    rst_d   = rst_q;
    auto_d  = auto_q;
    case (state_q)
      IDLE, ERROR: begin
        if (i_req) begin
          state_d = HOLD;
          mode_d  = i_mode;
          err_d   = 1'b0;
          cfg_d   = 1'b0;
          retry_d = '0;
          hold_d  = '0;
          rst_d   = 1'b1;
        end
      end
      HOLD: begin
        // Power-up run has no accepted request: take the mode pins here once.
        if (auto_q) begin
          mode_d = i_mode;
          auto_d = 1'b0;
        end
        if (hold_q >= HW'(RST_HOLD - 1)) begin
          state_d = ROM;
          idx_d   = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ROM: state_d = RD;
      RD: begin
        addr_d  = i_rom_data[38:32];
        mask_d  = i_rom_data[31:16];
        val_d   = i_rom_data[15:0];
        drp_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (i_drp_drdy) begin
          di_d    = (i_drp_do & mask_q) | val_q;
          state_d = WR;
        end else if (drp_q >= DW'(DRP_TIMEOUT - 1)) begin
          state_d = ERROR;
        end else begin
          drp_d = drp_q + 1'b1;
        end
      end
      WR: begin
        drp_d   = '0;
        state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (i_drp_drdy) begin
          if (idx_q == EW'(ENTRIES - 1)) begin
            state_d = RELEASE;
            rst_d   = 1'b0;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ROM;
          end
        end else if (drp_q >= DW'(DRP_TIMEOUT - 1)) begin
          state_d = ERROR;
        end else begin
          drp_d = drp_q + 1'b1;
        end
      end
      RELEASE: begin
        lock_d  = '0;
        state_d = LOCK_WAIT;
      end
      LOCK_WAIT: begin
        if (lk_sync_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cfg_d   = 1'b1;
        end else if (lock_q >= LW'(LOCK_TIMEOUT - 1)) begin
          if (retry_q < RW'(RETRIES)) begin
            retry_d = retry_q + 1'b1;
            hold_d  = '0;
            rst_d   = 1'b1;
            state_d = HOLD;
          end else begin
            state_d = ERROR;
          end
        end else begin
          lock_d = lock_q + 1'b1;
        end
      end
      default: state_d = ERROR;
    endcase
    // Every path into ERROR (DRP timeout, lock exhaustion) lands here.
    if (state_d == ERROR && state_q != ERROR) begin
      err_d = 1'b1;
      rst_d = 1'b1;
      cfg_d = 1'b0;
    end
  end

  assign o_busy      = !(state_q == IDLE || state_q == ERROR);
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_clk_valid = (state_q == IDLE) && cfg_q && lk_sync_q;
  assign o_rom_addr  = {mode_q, idx_q};
  assign o_drp_den   = (state_q == RD) || (state_q == WR);
  assign o_drp_dwe   = (state_q == WR);
  // ROM data is only valid during RD; later accesses use the captured copy.
  assign o_drp_daddr = (state_q == RD) ? i_rom_data[38:32] : addr_q;
  assign o_drp_di    = di_q;
  assign o_mmcm_rst  = rst_q;
endmodule

// File: tb/tb_display_clock_reconfig.sv
module tb_display_clock_reconfig;
  localparam int NE = 23;
  localparam int LOCK_DLY = 100;

  logic        i_clk = 0, i_rst_n, i_req, i_drp_drdy, i_mmcm_locked;
  logic [0:0]  i_mode;
  logic [5:0]  o_rom_addr;
  logic [38:0] i_rom_data = '0;
  logic [6:0]  o_drp_daddr;
  logic [15:0] o_drp_di, i_drp_do;
  logic        o_busy, o_done, o_err, o_clk_valid, o_drp_den, o_drp_dwe, o_mmcm_rst;

  display_clock_reconfig #(.LOCK_TIMEOUT(1000)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_mode(i_mode),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_clk_valid(o_clk_valid),
    .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data),
    .o_drp_den(o_drp_den), .o_drp_dwe(o_drp_dwe), .o_drp_daddr(o_drp_daddr),
    .o_drp_di(o_drp_di), .i_drp_do(i_drp_do), .i_drp_drdy(i_drp_drdy),
    .o_mmcm_rst(o_mmcm_rst), .i_mmcm_locked(i_mmcm_locked));

  always #5 i_clk = ~i_clk;

  typedef struct { logic we; logic [6:0] a; logic [15:0] d; } txn_t;
  txn_t txq[$], expq[$];

  logic [6:0]  rom_a [2][NE];
  logic [15:0] rom_m [2][NE], rom_v [2][NE];
  logic [15:0] mem [128], shadow [128];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0, rel_cnt = 0, rst_run = 0, den_cyc = 0, lk_cnt = 0, dly = 0;
  logic pend = 0, p_we = 0, prev_rst = 1, lock_en = 1, drdy_en = 1, exp_mode = 0;
  logic [6:0]  p_a = '0;
  logic [15:0] p_d = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Registered table ROM.
  always @(posedge i_clk)
    if (o_rom_addr[4:0] < NE)
      i_rom_data <= {rom_a[o_rom_addr[5]][o_rom_addr[4:0]],
                     rom_m[o_rom_addr[5]][o_rom_addr[4:0]],
                     rom_v[o_rom_addr[5]][o_rom_addr[4:0]]};

  // DRP slave (drdy 3 cycles after den), MMCM lock model, activity monitor.
  always @(negedge i_clk) begin
    cyc++;
    i_drp_drdy = 1'b0;
    if (!i_rst_n) begin
      pend    = 1'b0;
      rst_run = 0;
    end else begin
      rst_run = o_mmcm_rst ? rst_run + 1 : 0;
      if (o_done) done_cnt++;
      if (pend && drdy_en) begin
        dly--;
        if (dly == 0) begin
          i_drp_drdy = 1'b1;
          i_drp_do   = mem[p_a];
          if (p_we) mem[p_a] = p_d;
          pend = 1'b0;
        end
      end
      if (o_drp_den) begin
        chk("drp_overlap", pend, 0);
        chk("den_in_rst", (o_mmcm_rst && rst_run >= 17), 1);
        chk("rom_msb", o_rom_addr[5], exp_mode);
        txq.push_back('{we: o_drp_dwe, a: o_drp_daddr, d: o_drp_di});
        pend = 1'b1; dly = 3; p_a = o_drp_daddr; p_we = o_drp_dwe; p_d = o_drp_di;
        den_cyc = cyc;
      end
    end
    if (o_mmcm_rst) lk_cnt = 0;
    else if (lk_cnt < 1000000) lk_cnt++;
    if (prev_rst && !o_mmcm_rst) rel_cnt++;
    prev_rst = o_mmcm_rst;
    i_mmcm_locked = lock_en && (lk_cnt >= LOCK_DLY);
  end

  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  // Reference: each entry is a read of its address then a write of
  // (current & keep-mask) | value.
  task automatic build_expect(input int m, input int n);
    txn_t t;
    logic [15:0] nv;
    for (int e = 0; e < n; e++) begin
      t.we = 1'b0; t.a = rom_a[m][e]; t.d = '0;
      expq.push_back(t);
      nv = (shadow[t.a] & rom_m[m][e]) | rom_v[m][e];
      shadow[t.a] = nv;
      t.we = 1'b1; t.d = nv;
      expq.push_back(t);
    end
  endtask

  task automatic cmp_txns();
    chk("txn_count", txq.size(), expq.size());
    for (int i = 0; i < txq.size() && i < expq.size(); i++) begin
      chk("txn_we", txq[i].we, expq[i].we);
      chk("txn_addr", txq[i].a, expq[i].a);
      if (expq[i].we) chk("txn_wdata", txq[i].d, expq[i].d);
    end
    txq.delete();
    expq.delete();
  endtask

  task automatic wait_end(input int maxc);
    logic ended;
    int d0;
    d0 = done_cnt;
    ended = 1'b0;
    for (int c = 0; c < maxc && !ended; c++) begin
      tick();
      if (o_err || done_cnt != d0) ended = 1'b1;
    end
    chk("seq_end", ended, 1);
  endtask

  task automatic req(input logic m);
    i_mode = m;
    i_req  = 1'b1;
    tick();
    i_req  = 1'b0;
  endtask

  int d0, r0, dt;

  initial begin
    i_rst_n = 0; i_req = 0; i_mode = 0; i_drp_do = 0; i_drp_drdy = 0; i_mmcm_locked = 0;
    for (int m = 0; m < 2; m++)
      for (int e = 0; e < NE; e++) begin
        rom_a[m][e] = 7'($urandom);
        rom_m[m][e] = 16'($urandom);
        rom_v[m][e] = 16'($urandom);
      end
    for (int i = 0; i < 128; i++) begin
      mem[i] = 16'($urandom);
    end
    rom_a[0][0] = 7'h11; rom_m[0][0] = 16'hF000; rom_v[0][0] = 16'h0145;
    mem[7'h11] = 16'hA5A5;
    for (int i = 0; i < 128; i++) shadow[i] = mem[i];

    repeat (3) tick();
    chk("rst_busy", o_busy, 1);
    chk("rst_mmcm_rst", o_mmcm_rst, 1);
    chk("rst_den", o_drp_den, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    chk("rst_clk_valid", o_clk_valid, 0);
    chk("rst_rom_addr", o_rom_addr, 0);

    // 1/2: auto-start mode 0, full sequence, RMW of entry 0.
    exp_mode = 0;
    build_expect(0, NE);
    i_rst_n = 1;
    wait_end(3000);
    chk("t1_done", o_done, 1);
    chk("t1_clk_valid", o_clk_valid, 1);
    chk("t1_err", o_err, 0);
    chk("t1_mmcm_rst", o_mmcm_rst, 0);
    if (txq.size() > 1) chk("t2_rmw_di", txq[1].d, 16'hA145);
    else chk("t2_txn_present", txq.size(), 2);
    cmp_txns();
    repeat (5) tick();
    chk("t1_done_once", done_cnt, 1);

    // Lock loss while idle: valid drops, no self-triggered reconfig.
    lock_en = 0;
    repeat (4) tick();
    chk("lockloss_valid", o_clk_valid, 0);
    repeat (20) tick();
    chk("lockloss_busy", o_busy, 0);
    chk("lockloss_no_den", txq.size(), 0);
    lock_en = 1;
    repeat (4) tick();
    chk("relock_valid", o_clk_valid, 1);

    // 3: mode 1, extra requests while busy are ignored.
    exp_mode = 1;
    build_expect(1, NE);
    d0 = done_cnt;
    req(1);
    chk("t3_busy", o_busy, 1);
    chk("t3_mmcm_rst", o_mmcm_rst, 1);
    chk("t3_clk_valid", o_clk_valid, 0);
    for (int k = 0; k < 3; k++) begin
      repeat (30) tick();
      i_mode = 0; i_req = 1;
      tick();
      i_req = 0;
    end
    wait_end(3000);
    chk("t3_done_cnt", done_cnt - d0, 1);
    cmp_txns();
    repeat (3) tick();
    chk("t3_idle", o_busy, 0);

    // 4: DRP never answers.
    drdy_en = 0;
    exp_mode = 0;
    req(0);
    wait_end(500);
    dt = cyc - den_cyc;
    chk("t4_err", o_err, 1);
    chk("t4_busy", o_busy, 0);
    chk("t4_mmcm_rst", o_mmcm_rst, 1);
    chk("t4_timeout_window", (dt >= 64 && dt <= 66), 1);
    chk("t4_one_read", txq.size(), 1);
    txq.delete();
    drdy_en = 1;
    pend = 0;
    build_expect(0, NE);
    req(0);
    chk("t4_err_cleared", o_err, 0);
    chk("t4_rebusy", o_busy, 1);
    wait_end(3000);
    chk("t4_done", o_done, 1);
    cmp_txns();
    repeat (3) tick();

    // 5: lock never rises -> 1 + 2 retries, then error.
    lock_en = 0;
    exp_mode = 1;
    for (int k = 0; k < 3; k++) build_expect(1, NE);
    d0 = done_cnt;
    r0 = rel_cnt;
    req(1);
    wait_end(6000);
    chk("t5_err", o_err, 1);
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_releases", rel_cnt - r0, 3);
    chk("t5_mmcm_rst", o_mmcm_rst, 1);
    chk("t5_busy", o_busy, 0);
    cmp_txns();
    lock_en = 1;

    // 6: async reset during write of entry 10, then fresh start.
    exp_mode = 0;
    req(0);
    for (int c = 0; c < 1000 && txq.size() < 22; c++) tick();
    chk("t6_reached_wr10", txq.size(), 22);
    i_rst_n = 0;
    #1;
    chk("t6_busy", o_busy, 1);
    chk("t6_mmcm_rst", o_mmcm_rst, 1);
    chk("t6_den", o_drp_den, 0);
    chk("t6_dwe", o_drp_dwe, 0);
    chk("t6_err", o_err, 0);
    chk("t6_done", o_done, 0);
    chk("t6_rom_addr", o_rom_addr, 0);
    chk("t6_di", o_drp_di, 0);
    if (txq.size() == 22) begin
      chk("t6_wr10_we", txq[21].we, 1);
      chk("t6_wr10_addr", txq[21].a, rom_a[0][10]);
      chk("t6_rd10_addr", txq[20].a, rom_a[0][10]);
      void'(txq.pop_back());
      void'(txq.pop_back());
    end
    build_expect(0, 10);
    cmp_txns();
    repeat (5) tick();
    i_mode = 0;
    build_expect(0, NE);
    i_rst_n = 1;
    wait_end(3000);
    chk("t6_redone", o_done, 1);
    chk("t6_clk_valid", o_clk_valid, 1);
    cmp_txns();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
